// File: rtl/mux_rr_pipe_if.sv
// Channel-side and output-side signals of the registered N:1 mux.
// The master side drives channel data/valid, select controls and output
// ready; the slave side (the mux) returns per-channel ready and the
// registered output word.
interface mux_rr_pipe_if #(
  parameter int WIDTH = 16,
  parameter int NCH   = 8,
  parameter int SELW  = 3
);
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic                 mode;
  logic [SELW-1:0]      b;
  logic [WIDTH-1:0]     out0;
  logic                 out_valid;
  logic                 out_ready;
  logic [SELW-1:0]      out_ch;

  modport master (
    output in_data, in_valid, mode, b, out_ready,
    input  in_ready, out0, out_valid, out_ch
  );

  modport slave (
    input  in_data, in_valid, mode, b, out_ready,
    output in_ready, out0, out_valid, out_ch
  );
endinterface

// File: rtl/mux_rr_pipe.sv
// Registered N:1 channel mux with valid/ready handshakes.
// mode=0 grants the channel named by b; mode=1 grants round-robin starting
// after the last granted channel. One output register stage, one word per
// cycle throughput, backpressure holds the output word and stalls all inputs.
module mux_rr_pipe #(
  parameter int WIDTH = 16,
  parameter int NCH   = 8,
  parameter int SELW  = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_rr_pipe_if.slave  bus
);

  logic [WIDTH-1:0] data_p1;
  logic [SELW-1:0]  ch_p1;
  logic             vld_p1;
  logic [SELW-1:0]  rr_ptr;

  logic             open_p0;
  logic             gnt_hit_p0;
  logic [SELW-1:0]  gnt_idx_p0;
  logic             accept_p0;

  // Output register may take a word when empty or being drained this cycle.
  assign open_p0 = !vld_p1 || bus.out_ready;

  // Grant selection: fixed select, or first valid channel after rr_ptr.
  always_comb begin
    logic [SELW-1:0] cand;
    gnt_hit_p0 = 1'b0;
    gnt_idx_p0 = '0;
    cand       = '0;
    if (!bus.mode) begin
      if (int'(bus.b) < NCH) begin
        if (bus.in_valid[bus.b]) begin
          gnt_hit_p0 = 1'b1;
          gnt_idx_p0 = bus.b;
        end
      end
    end else begin
      for (int k = 1; k <= NCH; k++) begin
        cand = SELW'((int'(rr_ptr) + k) % NCH);
        if (!gnt_hit_p0 && bus.in_valid[cand]) begin
          gnt_hit_p0 = 1'b1;
          gnt_idx_p0 = cand;
        end
      end
    end
  end

  // Reset gating keeps every ready low while rst_n is asserted.
  assign accept_p0    = gnt_hit_p0 && open_p0 && rst_n;
  assign bus.in_ready = accept_p0 ? (NCH'(1) << gnt_idx_p0) : '0;

  // ---- stage p0 -> p1: output register and round-robin pointer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
      rr_ptr  <= SELW'(NCH - 1);
    end else begin
      if (open_p0) begin
        vld_p1 <= accept_p0;
      end
      if (accept_p0) begin
        data_p1 <= bus.in_data[int'(gnt_idx_p0)*WIDTH +: WIDTH];
        ch_p1   <= gnt_idx_p0;
        if (bus.mode) begin
          rr_ptr <= gnt_idx_p0;
        end
      end
    end
  end

  assign bus.out0      = data_p1;
  assign bus.out_ch    = ch_p1;
  assign bus.out_valid = vld_p1;

endmodule

// File: tb/tb_mux_rr_pipe.sv
// Bench for mux_rr_pipe: directed vector table, hand sequences for the
// multi-cycle cases, and randomized traffic against a transaction model.
module tb_mux_rr_pipe;
  localparam int WIDTH = 16;
  localparam int NCH   = 8;
  localparam int SELW  = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_rr_pipe_if #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) bus ();

  mux_rr_pipe #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Transaction model: what the output register should hold, and the
  // channel most recently granted in round-robin mode.
  bit               m_vld;
  logic [WIDTH-1:0] m_data;
  int               m_ch;
  int               m_ptr;

  logic [WIDTH-1:0] chan [NCH];

  typedef struct {
    bit         mode;
    logic [2:0] b;
    logic [7:0] valid;
    bit         ordy;
    logic [7:0] exp_rdy;
    bit         exp_vld;
    int         exp_ch;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic load_data();
    for (int i = 0; i < NCH; i++) bus.in_data[i*WIDTH +: WIDTH] = chan[i];
  endtask

  task automatic set_in(input bit mode, input logic [2:0] b, input logic [7:0] valid, input bit ordy);
    bus.mode      = mode;
    bus.b         = b;
    bus.in_valid  = valid;
    bus.out_ready = ordy;
    load_data();
  endtask

  function automatic void model_reset();
    m_vld  = 1'b0;
    m_data = '0;
    m_ch   = 0;
    m_ptr  = NCH - 1;
  endfunction

  // Channel the model grants for the current inputs, or -1.
  function automatic int model_grant();
    int order [$];
    if (m_vld && !bus.out_ready) return -1;
    if (!bus.mode) begin
      if (int'(bus.b) < NCH && bus.in_valid[bus.b]) return int'(bus.b);
      return -1;
    end
    for (int k = 1; k <= NCH; k++) order.push_back((m_ptr + k) % NCH);
    foreach (order[i]) if (bus.in_valid[order[i]]) return order[i];
    return -1;
  endfunction

  // Sample ready before the edge, clock once, sample outputs after it.
  task automatic tick(output logic [NCH-1:0] rdy, output int g);
    #1;
    rdy = bus.in_ready;
    g   = model_grant();
    @(posedge clk);
    if (g >= 0) begin
      m_vld  = 1'b1;
      m_data = chan[g];
      m_ch   = g;
      if (bus.mode) m_ptr = g;
    end else if (!m_vld || bus.out_ready) begin
      m_vld = 1'b0;
    end
    #1;
  endtask

  task automatic check_model(input string tag, input logic [NCH-1:0] rdy, input int g);
    logic [NCH-1:0] exp_rdy;
    exp_rdy = (g >= 0) ? (NCH'(1) << g) : '0;
    check({tag, "_ready"}, rdy, exp_rdy);
    check({tag, "_vld"}, bus.out_valid, m_vld);
    check({tag, "_out0"}, bus.out0, m_data);
    check({tag, "_ch"}, bus.out_ch, m_ch);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [NCH-1:0] rdy;
    int g;
    logic [WIDTH-1:0] held_d;
    logic [SELW-1:0]  held_c;

    for (int i = 0; i < NCH; i++) chan[i] = 16'h1000 + 16'(i) * 16'h0101;
    chan[3] = 16'hA5A5;

    tbl[0]  = '{1'b0, 3'd3, 8'hFF, 1'b1, 8'h08, 1'b1, 3};
    tbl[1]  = '{1'b0, 3'd5, 8'hDF, 1'b1, 8'h00, 1'b0, 3};
    tbl[2]  = '{1'b0, 3'd0, 8'h01, 1'b1, 8'h01, 1'b1, 0};
    tbl[3]  = '{1'b0, 3'd7, 8'h80, 1'b0, 8'h00, 1'b1, 0};
    tbl[4]  = '{1'b0, 3'd7, 8'h80, 1'b1, 8'h80, 1'b1, 7};
    tbl[5]  = '{1'b1, 3'd0, 8'h84, 1'b1, 8'h04, 1'b1, 2};
    tbl[6]  = '{1'b1, 3'd0, 8'h84, 1'b1, 8'h80, 1'b1, 7};
    tbl[7]  = '{1'b1, 3'd0, 8'h84, 1'b1, 8'h04, 1'b1, 2};
    tbl[8]  = '{1'b1, 3'd0, 8'h00, 1'b1, 8'h00, 1'b0, 2};
    tbl[9]  = '{1'b0, 3'd2, 8'h04, 1'b1, 8'h04, 1'b1, 2};
    tbl[10] = '{1'b1, 3'd0, 8'hFF, 1'b1, 8'h08, 1'b1, 3};

    // Reset state, with requests pending that must not be granted.
    rst_n = 1'b0;
    model_reset();
    set_in(1'b0, 3'd3, 8'hFF, 1'b1);
    #2;
    check("rst_vld", bus.out_valid, 1'b0);
    check("rst_out0", bus.out0, 16'h0);
    check("rst_ch", bus.out_ch, 3'd0);
    check("rst_ready", bus.in_ready, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 11; i++) begin
      set_in(tbl[i].mode, tbl[i].b, tbl[i].valid, tbl[i].ordy);
      tick(rdy, g);
      check($sformatf("tbl%0d_ready", i), rdy, tbl[i].exp_rdy);
      check($sformatf("tbl%0d_vld", i), bus.out_valid, tbl[i].exp_vld);
      check($sformatf("tbl%0d_ch", i), bus.out_ch, 32'(tbl[i].exp_ch));
      check($sformatf("tbl%0d_out0", i), bus.out0, chan[tbl[i].exp_ch]);
    end

    // Round-robin from reset with every channel valid.
    do_reset();
    set_in(1'b1, 3'd0, 8'hFF, 1'b1);
    for (int k = 0; k < 10; k++) begin
      tick(rdy, g);
      check($sformatf("rr%0d_ch", k), bus.out_ch, 32'(k % NCH));
      check($sformatf("rr%0d_vld", k), bus.out_valid, 1'b1);
      check($sformatf("rr%0d_out0", k), bus.out0, chan[k % NCH]);
    end

    // Backpressure for three cycles, then simultaneous drain and load.
    held_d = bus.out0;
    held_c = bus.out_ch;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(rdy, g);
      check($sformatf("bp%0d_ready", k), rdy, 8'h00);
      check($sformatf("bp%0d_vld", k), bus.out_valid, 1'b1);
      check($sformatf("bp%0d_out0", k), bus.out0, held_d);
      check($sformatf("bp%0d_ch", k), bus.out_ch, held_c);
    end
    bus.out_ready = 1'b1;
    tick(rdy, g);
    check("bp_release_ready", rdy, 8'h04);
    check("bp_release_vld", bus.out_valid, 1'b1);
    check("bp_release_ch", bus.out_ch, 3'd2);
    check("bp_release_out0", bus.out0, chan[2]);

    // Asynchronous reset between edges, then round-robin restarts at 0.
    tick(rdy, g);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_vld", bus.out_valid, 1'b0);
    check("arst_out0", bus.out0, 16'h0);
    check("arst_ch", bus.out_ch, 3'd0);
    check("arst_ready", bus.in_ready, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick(rdy, g);
    check("arst_first_ready", rdy, 8'h01);
    check("arst_first_ch", bus.out_ch, 3'd0);
    check("arst_first_vld", bus.out_valid, 1'b1);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NCH; i++) chan[i] = 16'($urandom);
      set_in(1'($urandom), 3'($urandom),
             ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom & $urandom),
             ($urandom_range(0, 3) != 0));
      tick(rdy, g);
      check_model($sformatf("rnd%0d", n), rdy, g);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux_rr_pipe.md
MUX_RR_PIPE -- requirements
Module: mux_rr_pipe

Interface
REQ-001 Parameter WIDTH, default 16, data width of every channel and of the output.
REQ-002 Parameter NCH, default 8, channel count; legal range 2..16.
REQ-003 Parameter SELW, default 3, select/channel-index width; SHALL equal ceil(log2(NCH)).
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST_N  input  1  reset, asynchronous assert, active-low; synchronous release to CLK is the integrator's responsibility.
REQ-006 IN  input  NCH*WIDTH  flattened channel data; channel i occupies IN[i*WIDTH +: WIDTH].
REQ-007 IN_VALID  input  NCH  channel i presents valid data.
REQ-008 IN_READY  output  NCH  channel i data accepted this cycle when IN_VALID[i] and IN_READY[i] are both 1.
REQ-009 MODE  input  1  0 = fixed select by B; 1 = round-robin across valid channels.
REQ-010 B  input  SELW  channel select, used only when MODE=0.
REQ-011 OUT0  output  WIDTH  registered selected data.
REQ-012 OUT_VALID  output  1  OUT0 holds an unconsumed word.
REQ-013 OUT_READY  input  1  downstream accepts OUT0 when OUT_VALID=1.
REQ-014 OUT_CH  output  SELW  index of the channel that supplied OUT0.

Function
REQ-015 Output register SHALL be "open" in a cycle when OUT_VALID=0 or OUT_READY=1.
REQ-016 At most one IN_READY bit SHALL be 1 per cycle; IN_READY SHALL be 0 for every channel when the output register is not open.
REQ-017 MODE=0: grant SHALL be channel B when IN_VALID[B]=1 and the register is open; no other channel is granted; B>=NCH grants nothing.
REQ-018 MODE=1: grant SHALL be the first channel with IN_VALID=1 searching PTR+1, PTR+2, ... modulo NCH, wrapping past NCH-1 to 0.
REQ-019 PTR (SELW bits, internal) SHALL update to the granted index on every accepted transfer in MODE=1 and SHALL hold otherwise, including throughout MODE=0.
REQ-020 IN_READY SHALL be combinational from IN_VALID, MODE, B, PTR, OUT_VALID, OUT_READY; it SHALL NOT depend on IN data.
REQ-021 On an accepted transfer, OUT0 <= granted channel data, OUT_CH <= granted index, OUT_VALID <= 1 at the next edge; latency one cycle.
REQ-022 Open register with no grant: OUT_VALID <= 0; OUT0 and OUT_CH SHALL hold their previous values.
REQ-023 OUT_VALID=1 and OUT_READY=0: OUT0, OUT_CH, OUT_VALID SHALL hold; no channel is accepted (backpressure).
REQ-024 Simultaneous consume and accept (OUT_VALID=1, OUT_READY=1, grant present) SHALL load the new word with OUT_VALID staying 1; full throughput of one word per cycle.
REQ-025 MODE or B changes SHALL take effect in the same cycle's grant; an already-registered word is unaffected.
REQ-026 Round-robin SHALL guarantee that a continuously valid channel is granted within NCH accepted transfers.

Reset
REQ-027 RST_N=0 SHALL immediately force OUT_VALID=0, OUT0=0, OUT_CH=0, PTR=NCH-1, independent of CLK.
REQ-028 During reset IN_READY SHALL be 0 for all channels; a word in flight at reset assertion is discarded.
REQ-029 First round-robin grant after reset SHALL favour channel 0.

Verification
REQ-030 Reset then MODE=0, B=3, IN_VALID=8'hFF, channel 3 data 16'hA5A5, OUT_READY=1 -> IN_READY=8'h08; next cycle OUT0=16'hA5A5, OUT_CH=3, OUT_VALID=1.
REQ-031 MODE=1, all 8 channels valid, OUT_READY=1 for 10 cycles after reset -> OUT_CH sequence 0,1,2,3,4,5,6,7,0,1.
REQ-032 MODE=1, IN_VALID=8'b1000_0100, PTR=2 -> grant 7, then 2, then 7 (wrap-around).
REQ-033 OUT_VALID=1, OUT_READY=0 for 3 cycles -> IN_READY=0, OUT0/OUT_CH stable; OUT_READY=1 on cycle 4 -> new word loaded same edge, OUT_VALID stays 1.
REQ-034 MODE=0, B=5, IN_VALID[5]=0, others 1 -> IN_READY=0; after consume OUT_VALID=0 with OUT0 held.
REQ-035 RST_N driven low mid-stream between edges -> OUT_VALID, OUT0, OUT_CH go to 0 without a clock edge; after release the next round-robin grant is channel 0.
